rsa_keygen_sequencer: RTL and testbench

Top-level controller for RSA key generation. It runs the shared prime generator twice to obtain P and Q, then computes n = P·Q and phi = (P−1)(Q−1) with an internal shift-add multiplier. It then drives the E-key generator and the D-key generator in turn with phi, and grants the single RNG to whichever stage is active. It sits between the host/UART command logic and the key-generation datapath blocks.

---
 rtl/rsa_keygen_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_rsa_keygen_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_keygen_sequencer.sv
// rsa_keygen_sequencer
//
// Top-level controller for RSA key generation. The shared prime generator is
// run twice to obtain P and Q (Q is regenerated while it equals P). An
// internal shift-add multiplier then forms n = P*Q and phi = (P-1)(Q-1). The
// E-key and D-key generators are run in turn with phi. The single RNG is
// granted to whichever random stage currently owns the datapath.
//
// Optional feature: define KEYGEN_WATCHDOG_EN to add a per-stage timeout
// (WDOG_CYCLES). A stage that runs that long sends the FSM to ERR for one
// cycle and sets the sticky error flag. Without the macro there is no
// counter, no ERR state, and error is tied to 0.
//
// Handshake: each generator enable (prime_en, e_en, d_en) is held high while
// its stage is active. The matching *_valid input is sampled on every rising
// edge while the enable is high, and its data is captured in the same edge.
// The enable drops in the following cycle. A valid seen while the enable is
// low is ignored.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   start               request a new key set (accepted only in IDLE)
//   busy, done, error   status: not-idle, one-cycle completion, sticky timeout
//   prime_en/valid/in   prime generator handshake (PRIME_W-bit result)
//   e_en/valid/in       E-key generator handshake (KEY_W-bit result)
//   d_en/valid/in       D-key generator handshake (KEY_W-bit result)
//   prime_rng_req,
//   e_rng_req, rng_en   RNG requests from the random stages and the grant
//   phi, n_key,
//   e_key, d_key        registered key results
//   state_dbg           current FSM state, for observation only
module rsa_keygen_sequencer #(
  parameter int PRIME_W     = 16,
  parameter int KEY_W       = 32,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               prime_en,
  input  logic               prime_valid,
  input  logic [PRIME_W-1:0] prime_in,
  output logic               e_en,
  input  logic               e_valid,
  input  logic [KEY_W-1:0]   e_in,
  output logic               d_en,
  input  logic               d_valid,
  input  logic [KEY_W-1:0]   d_in,
  input  logic               prime_rng_req,
  input  logic               e_rng_req,
  output logic               rng_en,
  output logic [KEY_W-1:0]   phi,
  output logic [KEY_W-1:0]   n_key,
  output logic [KEY_W-1:0]   e_key,
  output logic [KEY_W-1:0]   d_key,
  output logic [3:0]         state_dbg
);

  localparam int CNT_W = $clog2(PRIME_W) + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GEN_P,
    S_GAP,
    S_GEN_Q,
    S_CHECK,
    S_MUL,
    S_GEN_E,
    S_GEN_D,
    S_DONE
`ifdef KEYGEN_WATCHDOG_EN
    , S_ERR
`endif
  } state_t;

  state_t             state;
  logic [PRIME_W-1:0] p_reg;
  logic [PRIME_W-1:0] q_reg;

  // Multiplier datapath: two independent shift-add lanes share one bit
  // counter. The multiplicand shifts left and the multiplier shifts right,
  // so bit 0 of the multiplier always selects the current partial product.
  logic [KEY_W-1:0]   mcand_n;
  logic [KEY_W-1:0]   mcand_phi;
  logic [PRIME_W-1:0] mplier_n;
  logic [PRIME_W-1:0] mplier_phi;
  logic [KEY_W-1:0]   acc_n;
  logic [KEY_W-1:0]   acc_phi;
  logic [CNT_W-1:0]   bit_cnt;
  logic [KEY_W-1:0]   sum_n;
  logic [KEY_W-1:0]   sum_phi;
  logic [PRIME_W-1:0] p_dec;
  logic [PRIME_W-1:0] q_dec;
  logic               mul_last;

  assign p_dec    = p_reg - PRIME_W'(1);
  assign q_dec    = q_reg - PRIME_W'(1);
  assign sum_n    = acc_n + (mplier_n[0] ? mcand_n : '0);
  assign sum_phi  = acc_phi + (mplier_phi[0] ? mcand_phi : '0);
  assign mul_last = (bit_cnt == CNT_W'(PRIME_W - 1));

  // Status and enables decode directly from the state register.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign prime_en  = (state == S_GEN_P) || (state == S_GEN_Q);
  assign e_en      = (state == S_GEN_E);
  assign d_en      = (state == S_GEN_D);
  assign rng_en    = (prime_en & prime_rng_req) | (e_en & e_rng_req);
  assign state_dbg = state;

`ifdef KEYGEN_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_count;
  logic            wd_leave;
  logic            wd_hit;

  // The counter restarts whenever a counted stage is left, so each stage
  // (including the direct GEN_E -> GEN_D hand-over) gets a full budget.
  assign wd_count = prime_en | e_en | d_en;
  assign wd_leave = (prime_en & prime_valid) | (e_en & e_valid) | (d_en & d_valid);
  assign wd_hit   = wd_count & (wd_cnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || !wd_count || wd_leave || wd_hit) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      p_reg      <= '0;
      q_reg      <= '0;
      mcand_n    <= '0;
      mcand_phi  <= '0;
      mplier_n   <= '0;
      mplier_phi <= '0;
      acc_n      <= '0;
      acc_phi    <= '0;
      bit_cnt    <= '0;
      phi        <= '0;
      n_key      <= '0;
      e_key      <= '0;
      d_key      <= '0;
`ifdef KEYGEN_WATCHDOG_EN
      error      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_GEN_P;
            phi   <= '0;
            n_key <= '0;
            e_key <= '0;
            d_key <= '0;
`ifdef KEYGEN_WATCHDOG_EN
            error <= 1'b0;
`endif
          end
        end
        S_GEN_P: begin
          if (prime_valid) begin
            p_reg <= prime_in;
            state <= S_GAP;
          end
`ifdef KEYGEN_WATCHDOG_EN
          else if (wd_hit) begin
            state <= S_ERR;
            error <= 1'b1;
          end
`endif
        end
        // One cycle with prime_en low so the generator restarts for Q.
        S_GAP: state <= S_GEN_Q;
        S_GEN_Q: begin
          if (prime_valid) begin
            q_reg <= prime_in;
            state <= S_CHECK;
          end
`ifdef KEYGEN_WATCHDOG_EN
          else if (wd_hit) begin
            state <= S_ERR;
            error <= 1'b1;
          end
`endif
        end
        S_CHECK: begin
          if (q_reg == p_reg) begin
            state <= S_GAP;
          end else begin
            acc_n      <= '0;
            acc_phi    <= '0;
            mcand_n    <= KEY_W'(p_reg);
            mcand_phi  <= KEY_W'(p_dec);
            mplier_n   <= q_reg;
            mplier_phi <= q_dec;
            bit_cnt    <= '0;
            state      <= S_MUL;
          end
        end
        S_MUL: begin
          acc_n      <= sum_n;
          acc_phi    <= sum_phi;
          mcand_n    <= mcand_n << 1;
          mcand_phi  <= mcand_phi << 1;
          mplier_n   <= mplier_n >> 1;
          mplier_phi <= mplier_phi >> 1;
          bit_cnt    <= bit_cnt + CNT_W'(1);
          // The final partial product goes straight into the result
          // registers, so phi is stable for the whole of GEN_E and GEN_D.
          if (mul_last) begin
            n_key <= sum_n;
            phi   <= sum_phi;
            state <= S_GEN_E;
          end
        end
        S_GEN_E: begin
          if (e_valid) begin
            e_key <= e_in;
            state <= S_GEN_D;
          end
`ifdef KEYGEN_WATCHDOG_EN
          else if (wd_hit) begin
            state <= S_ERR;
            error <= 1'b1;
          end
`endif
        end
        S_GEN_D: begin
          if (d_valid) begin
            d_key <= d_in;
            state <= S_DONE;
          end
`ifdef KEYGEN_WATCHDOG_EN
          else if (wd_hit) begin
            state <= S_ERR;
            error <= 1'b1;
          end
`endif
        end
        S_DONE: state <= S_IDLE;
`ifdef KEYGEN_WATCHDOG_EN
        S_ERR: state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_keygen_sequencer.sv
// Self-checking bench for rsa_keygen_sequencer (default build).
// The bench plays all three generators itself. For every cycle it decides
// which stage the key-generation timeline is in, using the stage lengths it
// chose. From that it drives the inputs and queues the outputs the DUT must
// show. The inputs include random RNG requests, spurious valids outside the
// owning stage, and stray start pulses while busy. A single compare process
// pops one expectation per cycle and checks it on the falling edge.
module tb_rsa_keygen_sequencer;

  localparam int PW = 16;
  localparam int KW = 32;

  localparam int ST_IDLE  = 0;
  localparam int ST_PRIME = 1;
  localparam int ST_GAP   = 2;
  localparam int ST_CHECK = 3;
  localparam int ST_MUL   = 4;
  localparam int ST_E     = 5;
  localparam int ST_D     = 6;
  localparam int ST_DONE  = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic          prime_en, e_en, d_en, rng_en;
  logic          prime_valid = 1'b0;
  logic [PW-1:0] prime_in = '0;
  logic          e_valid = 1'b0;
  logic [KW-1:0] e_in = '0;
  logic          d_valid = 1'b0;
  logic [KW-1:0] d_in = '0;
  logic          prime_rng_req = 1'b0;
  logic          e_rng_req = 1'b0;
  logic [KW-1:0] phi, n_key, e_key, d_key;
  logic [3:0]    state_dbg;

  rsa_keygen_sequencer #(.PRIME_W(PW), .KEY_W(KW), .WDOG_CYCLES(65535)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .error(error),
    .prime_en(prime_en), .prime_valid(prime_valid), .prime_in(prime_in),
    .e_en(e_en), .e_valid(e_valid), .e_in(e_in),
    .d_en(d_en), .d_valid(d_valid), .d_in(d_in),
    .prime_rng_req(prime_rng_req), .e_rng_req(e_rng_req), .rng_en(rng_en),
    .phi(phi), .n_key(n_key), .e_key(e_key), .d_key(d_key),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          busy;
    logic          done;
    logic          pen;
    logic          een;
    logic          den;
    logic          rng;
    logic [KW-1:0] n;
    logic [KW-1:0] phi;
    logic [KW-1:0] e;
    logic [KW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  // Model of the result registers as the host should see them.
  logic [KW-1:0] m_n = '0, m_phi = '0, m_e = '0, m_d = '0;

  function automatic void chk(string name, logic [KW-1:0] act, logic [KW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("busy",     KW'(busy),     KW'(cur.busy));
      chk("done",     KW'(done),     KW'(cur.done));
      chk("error",    KW'(error),    '0);
      chk("prime_en", KW'(prime_en), KW'(cur.pen));
      chk("e_en",     KW'(e_en),     KW'(cur.een));
      chk("d_en",     KW'(d_en),     KW'(cur.den));
      chk("rng_en",   KW'(rng_en),   KW'(cur.rng));
      chk("n_key",    n_key,         cur.n);
      chk("phi",      phi,           cur.phi);
      chk("e_key",    e_key,         cur.e);
      chk("d_key",    d_key,         cur.d);
    end
  end

  // ---------------- driver ----------------
  // Drives one cycle of stimulus for timeline stage stg and queues what the
  // outputs must look like during that cycle. own_v marks the cycle in which
  // the owning generator reports its result (data).
  task automatic do_cycle(input int stg, input logic own_v, input logic [KW-1:0] data,
                          input logic start_in, input logic rst_in);
    exp_t x;
    logic preq, ereq;
    preq = 1'($urandom_range(0, 1));
    ereq = 1'($urandom_range(0, 1));
    prime_rng_req = preq;
    e_rng_req     = ereq;
    prime_valid = (stg == ST_PRIME) ? own_v : ($urandom_range(0, 3) == 0);
    prime_in    = (stg == ST_PRIME && own_v) ? data[PW-1:0] : PW'($urandom);
    e_valid     = (stg == ST_E) ? own_v : ($urandom_range(0, 3) == 0);
    e_in        = (stg == ST_E && own_v) ? data : $urandom;
    d_valid     = (stg == ST_D) ? own_v : ($urandom_range(0, 3) == 0);
    d_in        = (stg == ST_D && own_v) ? data : $urandom;
    start = (stg == ST_IDLE) ? start_in : (start_in | ($urandom_range(0, 5) == 0));
    rst   = ~rst_in;
    x.busy = (stg != ST_IDLE);
    x.done = (stg == ST_DONE);
    x.pen  = (stg == ST_PRIME);
    x.een  = (stg == ST_E);
    x.den  = (stg == ST_D);
    x.rng  = (stg == ST_PRIME) ? preq : ((stg == ST_E) ? ereq : 1'b0);
    x.n    = m_n;
    x.phi  = m_phi;
    x.e    = m_e;
    x.d    = m_d;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    m_n = '0; m_phi = '0; m_e = '0; m_d = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle(ST_IDLE, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic gen_stage(input int stg, input logic [KW-1:0] data, input logic first_start);
    int t;
    t = $urandom_range(1, 5);
    for (int i = 0; i < t; i++)
      do_cycle(stg, (i == t - 1), data, first_start && (i == 0), 1'b0);
  endtask

  // One key-generation run. With retry set, the prime generator first
  // returns P again for Q. mul_abort > 0 asserts reset in that MUL cycle.
  task automatic run_keyset(input logic [PW-1:0] p, input logic [PW-1:0] q, input logic retry,
                            input logic [KW-1:0] e, input logic [KW-1:0] d, input int mul_abort);
    logic [PW-1:0] pm1, qm1;
    logic [KW-1:0] exp_n, exp_phi;
    pm1     = p - 1'b1;
    qm1     = q - 1'b1;
    exp_n   = KW'(p) * KW'(q);
    exp_phi = KW'(pm1) * KW'(qm1);
    do_cycle(ST_IDLE, 1'b0, '0, 1'b1, 1'b0);
    clear_model();
    gen_stage(ST_PRIME, KW'(p), 1'b0);
    if (retry) begin
      do_cycle(ST_GAP, 1'b0, '0, 1'b0, 1'b0);
      gen_stage(ST_PRIME, KW'(p), 1'b0);
      do_cycle(ST_CHECK, 1'b0, '0, 1'b0, 1'b0);
    end
    do_cycle(ST_GAP, 1'b0, '0, 1'b0, 1'b0);
    gen_stage(ST_PRIME, KW'(q), 1'b0);
    do_cycle(ST_CHECK, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= PW; i++) begin
      if (i == mul_abort) begin
        do_cycle(ST_MUL, 1'b0, '0, 1'b0, 1'b1);
        clear_model();
        idle_cycles(2);
        return;
      end
      do_cycle(ST_MUL, 1'b0, '0, 1'b0, 1'b0);
    end
    m_n   = exp_n;
    m_phi = exp_phi;
    gen_stage(ST_E, e, 1'b1);   // a start pulse in GEN_E must be ignored
    m_e = e;
    gen_stage(ST_D, d, 1'b0);
    m_d = d;
    do_cycle(ST_DONE, 1'b0, '0, 1'b0, 1'b0);
    idle_cycles($urandom_range(1, 3));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [PW-1:0] p, q;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_cycle(ST_IDLE, 1'b0, '0, 1'b0, 1'b1);   // outputs under reset
    idle_cycles(2);

    // Textbook key set, then pin the model with literal values.
    run_keyset(16'd61, 16'd53, 1'b0, 32'd17, 32'd2753, 0);
    chk("lit_n_key", n_key, 32'd3233);
    chk("lit_phi",   phi,   32'd3120);
    chk("lit_e_key", e_key, 32'd17);
    chk("lit_d_key", d_key, 32'd2753);

    // Prime generator returns 61, 61, 53: one Q retry.
    run_keyset(16'd61, 16'd53, 1'b1, 32'd17, 32'd2753, 0);
    chk("lit_retry_n_key", n_key, 32'd3233);

    // Reset in the middle of MUL, then a normal run.
    run_keyset(16'd61, 16'd53, 1'b0, 32'd17, 32'd2753, 7);
    chk("lit_abort_n_key", n_key, 32'd0);
    run_keyset(16'd101, 16'd103, 1'b0, 32'd7, 32'd8743, 0);
    chk("lit_n_key_2", n_key, 32'd10403);
    chk("lit_phi_2",   phi,   32'd10200);

    // Widest operands: products need all KEY_W bits.
    run_keyset(16'hFFFF, 16'hFFFE, 1'b0, 32'hDEADBEEF, 32'h12345678, 0);
    chk("lit_n_key_max", n_key, 32'hFFFD0002);
    run_keyset(16'd2, 16'd3, 1'b0, 32'd1, 32'd1, 0);

    for (int k = 0; k < 25; k++) begin
      p = PW'($urandom_range(2, 65535));
      q = PW'($urandom_range(2, 65535));
      if (q == p) q = p ^ 16'd1;
      run_keyset(p, q, ($urandom_range(0, 3) == 0), $urandom, $urandom,
                 ($urandom_range(0, 7) == 0) ? $urandom_range(1, PW) : 0);
    end

    @(negedge clk);
    chk("scoreboard_drained", KW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
